// File: rtl/disp_serial_rx_if.sv
// disp_serial_rx_if: serial display link wires plus the rebuilt parallel frame.
interface disp_serial_rx_if #(parameter int WIDTH = 64);
  localparam int CW = $clog2(WIDTH + 2);
  logic s_clk;
  logic s_do;
  logic s_pen;
  logic s_clr_n;
  logic [WIDTH-1:0] data;
  logic valid;
  logic frame_err;
  logic [CW-1:0] bit_cnt;
  modport master (output s_clk, s_do, s_pen, s_clr_n, input data, valid, frame_err, bit_cnt);
  modport slave (input s_clk, s_do, s_pen, s_clr_n, output data, valid, frame_err, bit_cnt);
endinterface

// File: rtl/disp_serial_rx.sv
// disp_serial_rx: oversampling receiver for the display shift-register link.
// Define DISP_SERIAL_RX_FILTER_EN to add a 3-sample majority glitch filter.
module disp_serial_rx #(
  parameter int WIDTH = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  disp_serial_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  // bit 4 is a constant 1 that marks when the synchronizer holds real samples
  logic [SYNC_STAGES-1:0][4:0] r_sync;
  logic [4:0] w_sy;
  logic [4:0] w_in;
  logic r_clk_d, r_pen_d, r_clk_arm, r_pen_arm;
  logic w_clk_rise, w_pen_rise, w_clr;
  logic [WIDTH-1:0] r_shreg, w_shreg_next, r_data;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic r_valid, r_ferr;
  assign w_sy = r_sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], {1'b1, bus.s_clr_n, bus.s_pen, bus.s_do, bus.s_clk}};
`ifdef DISP_SERIAL_RX_FILTER_EN
  logic [4:0] r_h0, r_h1, r_flt, w_maj;
  assign w_maj = (w_sy & r_h0) | (w_sy & r_h1) | (r_h0 & r_h1);
  // data bypasses the vote but takes the same two-cycle delay as the strobes
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_h0  <= '0;
      r_h1  <= '0;
      r_flt <= '0;
    end else begin
      r_h0  <= w_sy;
      r_h1  <= r_h0;
      r_flt <= {w_maj[4:2], r_h0[1], w_maj[0]};
    end
  assign w_in = r_flt;
`else
  assign w_in = w_sy;
`endif
  // an input already high when reset lifts must be seen low before it can edge
  assign w_clk_rise = w_in[0] & ~r_clk_d & r_clk_arm;
  assign w_pen_rise = w_in[2] & ~r_pen_d & r_pen_arm;
  assign w_clr = ~w_in[3];
  always_comb begin
    w_shreg_next = w_clr ? '0 : w_clk_rise ? {r_shreg[WIDTH-2:0], w_in[1]} : r_shreg;
    w_cnt_next = w_clr ? '0 : (w_clk_rise && r_cnt != CNT_MAX) ? r_cnt + 1'b1 : r_cnt;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_clk_d   <= 1'b0;
      r_pen_d   <= 1'b0;
      r_clk_arm <= 1'b0;
      r_pen_arm <= 1'b0;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_clk_d   <= w_in[0];
      r_pen_d   <= w_in[2];
      r_clk_arm <= r_clk_arm | (w_in[4] & ~w_in[0]);
      r_pen_arm <= r_pen_arm | (w_in[4] & ~w_in[2]);
      r_shreg   <= w_shreg_next;
      r_cnt     <= w_pen_rise ? '0 : w_cnt_next;
      r_data    <= w_pen_rise ? w_shreg_next : r_data;
      r_valid   <= w_pen_rise;
      r_ferr    <= w_pen_rise ? (w_cnt_next != CNT_FULL) : r_ferr;
    end
  assign bus.data = r_data;
  assign bus.valid = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.bit_cnt = r_cnt;
endmodule

// File: tb/tb_disp_serial_rx.sv
// tb_disp_serial_rx: table-driven frames plus corner sequences, scoreboarded on valid.
module tb_disp_serial_rx;
  localparam int H = 6;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;
  disp_serial_rx_if #(.WIDTH(64)) bus();
  disp_serial_rx #(.WIDTH(64), .SYNC_STAGES(2)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {logic [63:0] d; logic e; logic chk_d;} exp_t;
  typedef struct {int n; logic [63:0] pat; logic [63:0] exp_d; logic exp_e; int exp_cnt;} vec_t;
  exp_t q[$];
  vec_t tbl[4];
  logic prev_v = 1'b0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.valid && prev_v) begin
      checks++;
      errors++;
      $display("FAIL valid_width got 2+ cycles expected 1");
    end
    if (bus.valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid got 1 expected 0");
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.chk_d) check("data", bus.data, e.d);
        check("frame_err", {63'b0, bus.frame_err}, {63'b0, e.e});
      end
    end
    prev_v <= bus.valid;
  end
  task automatic send_bit(input logic b, input logic glitch);
    bus.s_do = b;
    @(posedge clk);
    bus.s_clk = 1'b1;
    repeat (H) @(posedge clk);
    bus.s_clk = 1'b0;
    if (glitch) begin
      repeat (3) @(posedge clk);
      bus.s_clk = 1'b1;
      @(posedge clk);
      bus.s_clk = 1'b0;
    end
    repeat (H) @(posedge clk);
  endtask
  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i % 64], 1'b0);
  endtask
  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL valid_timeout got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask
  task automatic latch(input logic [63:0] d, input logic e, input logic chk_d);
    q.push_back('{d, e, chk_d});
    bus.s_pen = 1'b1;
    repeat (H) @(posedge clk);
    bus.s_pen = 1'b0;
    repeat (H) @(posedge clk);
    drain();
    @(negedge clk);
    check("cnt_after_latch", 64'(bus.bit_cnt), 64'd0);
  endtask
  initial begin
    logic [63:0] p;
    tbl[0] = '{64, 64'hDEADBEEF01234567, 64'hDEADBEEF01234567, 1'b0, 64};
    tbl[1] = '{63, 64'h0123456789ABCDEF, 64'h8123456789ABCDEF, 1'b1, 63};
    tbl[2] = '{66, 64'hCAFEF00D12345678, 64'hCAFEF00D12345678, 1'b1, 65};
    tbl[3] = '{64, 64'h5A5A5A5AA5A5A5A5, 64'h5A5A5A5AA5A5A5A5, 1'b0, 64};
    bus.s_clk = 1'b0;
    bus.s_do = 1'b0;
    bus.s_pen = 1'b0;
    bus.s_clr_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", bus.data, 64'd0);
    check("rst_valid", {63'b0, bus.valid}, 64'd0);
    check("rst_ferr", {63'b0, bus.frame_err}, 64'd0);
    check("rst_cnt", 64'(bus.bit_cnt), 64'd0);
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      send_bits(tbl[i].pat, tbl[i].n);
      @(negedge clk);
      check("cnt_before_latch", 64'(bus.bit_cnt), 64'(tbl[i].exp_cnt));
      latch(tbl[i].exp_d, tbl[i].exp_e, 1'b1);
    end
    send_bits(64'hABCDE, 20);
    @(negedge clk);
    check("cnt_before_clr", 64'(bus.bit_cnt), 64'd20);
    bus.s_clr_n = 1'b0;
    repeat (H) @(posedge clk);
    bus.s_clr_n = 1'b1;
    repeat (H) @(posedge clk);
    @(negedge clk);
    check("cnt_after_clr", 64'(bus.bit_cnt), 64'd0);
    send_bits(64'h00000000FFFFFFFF, 64);
    latch(64'h00000000FFFFFFFF, 1'b0, 1'b1);
    p = 64'h0123456789ABCDEF;
    send_bits(p >> 1, 63);
    @(negedge clk);
    check("cnt_before_same", 64'(bus.bit_cnt), 64'd63);
    bus.s_do = p[0];
    @(posedge clk);
    q.push_back('{p, 1'b0, 1'b1});
    bus.s_clk = 1'b1;
    bus.s_pen = 1'b1;
    repeat (H) @(posedge clk);
    bus.s_clk = 1'b0;
    bus.s_pen = 1'b0;
    repeat (H) @(posedge clk);
    drain();
    @(negedge clk);
    check("cnt_after_same", 64'(bus.bit_cnt), 64'd0);
    send_bits(64'h3FF, 10);
    latch(64'd0, 1'b1, 1'b0);
    send_bits(64'h12345678, 30);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrst_data", bus.data, 64'd0);
    check("midrst_ferr", {63'b0, bus.frame_err}, 64'd0);
    check("midrst_cnt", 64'(bus.bit_cnt), 64'd0);
    check("midrst_valid", {63'b0, bus.valid}, 64'd0);
    bus.s_clk = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(posedge clk);
    bus.s_clk = 1'b0;
    repeat (H) @(posedge clk);
    @(negedge clk);
    check("cnt_after_rst", 64'(bus.bit_cnt), 64'd0);
    send_bits(64'hFEDCBA9876543210, 64);
    @(negedge clk);
    check("cnt_before_rst_frame", 64'(bus.bit_cnt), 64'd64);
    latch(64'hFEDCBA9876543210, 1'b0, 1'b1);
    p = 64'h1122334455667788;
    for (int i = 63; i >= 0; i--) send_bit(p[i], i == 40 || i == 20);
    @(negedge clk);
`ifdef DISP_SERIAL_RX_FILTER_EN
    check("cnt_glitch", 64'(bus.bit_cnt), 64'd64);
    latch(p, 1'b0, 1'b1);
`else
    check("cnt_glitch", 64'(bus.bit_cnt), 64'd65);
    latch(p, 1'b1, 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/disp_serial_rx.md
# disp_serial_rx

Serial-display link receiver. It deserializes the clock/data/latch/clear stream that the board display driver shifts out to the segment and LED shift-register chains, and rebuilds the parallel frame inside the system clock domain. It sits next to the display driver and listens on the same four wires (`seg_*` or `led_*`), for loopback self-check and on-chip display mirroring. All serial inputs are asynchronous to `clk` and are oversampled.

## Interface
Parameters:
- `WIDTH`, default 64: frame length in bits (number of shift-register cells in the chain).
- `SYNC_STAGES`, default 2: flip-flop stages in the input synchronizer, minimum 2.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `s_clk`, input, 1: serial shift clock; a rising edge shifts one bit.
- `s_do`, input, 1: serial data, MSB first.
- `s_pen`, input, 1: latch enable; a rising edge latches the frame.
- `s_clr_n`, input, 1: active-low clear of the shift chain, level-sensitive.
- `data`, output, WIDTH: last latched frame.
- `valid`, output, 1: one-cycle pulse when `data` updates.
- `frame_err`, output, 1: the last latched frame did not contain exactly WIDTH shifts.
- `bit_cnt`, output, clog2(WIDTH+2): shifts received since the last latch or clear. Saturates at WIDTH+1.

## Operation
- Every serial input passes through its own SYNC_STAGES synchronizer. Edge detection compares the synchronized value against a one-cycle-delayed copy.
- Rising edge of `s_clk` (`clk_rise`):
  - `shreg <= {shreg[WIDTH-2:0], s_do_sync}`.
  - `bit_cnt` increments and saturates at WIDTH+1.
  - `s_do_sync` is the data sample delayed by the same number of stages, so it stays aligned with `clk_rise`.
- `s_clr_n_sync` low: `shreg <= 0`, `bit_cnt <= 0` on every cycle it is low.
- Rising edge of `s_pen` (`pen_rise`):
  - `data <= shreg_next`, where `shreg_next` is the value `shreg` takes this cycle, including any same-cycle shift or clear.
  - `valid <= 1` for exactly one cycle.
  - `frame_err <= (bit_cnt_next != WIDTH)`.
  - `bit_cnt <= 0`.
  - `shreg` is kept, matching a physical chain.
- Priority within one cycle: clear, then shift, then latch.
  - Clear together with shift: the clear wins and the shift is discarded.
  - Clear together with latch: the latch captures all zeros and reports `frame_err=1` (WIDTH > 0).
  - Shift together with latch: the latch includes the new bit, and the count used for `frame_err` includes that shift.
- `frame_err` holds until the next latch. `data` holds until the next latch.
- Reset (asserted at any time, including mid-frame) asynchronously forces:
  - `shreg=0`, `data=0`, `valid=0`, `frame_err=0`, `bit_cnt=0`;
  - all synchronizer and edge-history flops to 0.
  
  After release, an `s_clk` or `s_pen` input that is already high is not an edge: the history flops must first see it low.

## Timing
- Input pin to `shreg` update: SYNC_STAGES+1 `clk` cycles after the `s_clk` rising edge (SYNC_STAGES+3 with the filter enabled).
- Input pin to `valid`/`data`: SYNC_STAGES+1 cycles after the `s_pen` rising edge (SYNC_STAGES+3 with the filter).
- `s_clk`, `s_pen` and `s_clr_n` must each stay high and low for at least SYNC_STAGES+1 `clk` cycles (+2 with the filter).
- `s_do` must be stable from 1 cycle before to SYNC_STAGES+1 cycles after each `s_clk` rise.
- Narrower pulses may be lost. Lost pulses are not detected, except through `frame_err`.
- Throughput: one bit per 2·(SYNC_STAGES+1) `clk` cycles, worst case.

## Configuration
- `DISP_SERIAL_RX_FILTER_EN` defined:
  - 3-sample majority filter on the synchronized `s_clk`, `s_pen` and `s_clr_n`, placed before edge detection.
  - `s_do` gets a matching 2-cycle delay.
  - Isolated 1-cycle glitches are rejected.
  - Adds 2 cycles of latency.
- Undefined: no filter. A glitch of one cycle or longer that reaches the synchronized signal counts as an edge.

## Test plan
- Reset, then shift 64 bits of 0xDEADBEEF_01234567 MSB first, then pulse `s_pen` → one `valid` pulse, `data=0xDEADBEEF01234567`, `frame_err=0`, `bit_cnt=0`.
- 63-bit frame → `frame_err=1`. 66-bit frame → `frame_err=1` and `bit_cnt` reads 65 just before the latch. A following correct 64-bit frame → `frame_err=0`.
- Shift 20 bits, pulse `s_clr_n` low, then send a full frame of 0x0000_0000_FFFF_FFFF → `data` matches exactly, `frame_err=0`.
- `s_pen` rise in the same cycle as the 64th `s_clk` rise → `data` includes the final bit, `frame_err=0`.
- Assert `rstn` after 30 bits → all outputs 0 immediately. After release, a full frame latches correctly.
- With `DISP_SERIAL_RX_FILTER_EN`: inject 1-cycle glitches on `s_clk` during a frame → no extra shifts, `frame_err=0`. Without the macro, the same stimulus → `frame_err=1`.
